// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and register-file write port of
// the RV32I pipeline. Performs load alignment/extension, write-back source
// selection and misaligned-load detection ahead of the MEM/WB register.
// Optional feature: define WB_RETIRE_COUNTER_EN to enable the 64-bit
// retired-instruction counter on wb_instret (otherwise tied to zero).
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_hold,
    input  logic            wb_flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_wb_reg_file,
    input  logic            mem_memtoreg,
    input  logic            mem_jal,
    input  logic            mem_jalr,
    input  logic [2:0]      mem_load_type,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    output logic            wb_wr_en,
    output logic [4:0]      wb_wr_addr,
    output logic [XLEN-1:0] wb_wr_data,
    output logic            wb_valid,
    output logic            wb_misaligned,
    output logic [63:0]     wb_instret
);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Pick the addressed byte/halfword out of the raw word and extend it.
    // Unknown load types behave as LW.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [2:0]      ltype,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic signed [7:0]  byte_val;
        logic signed [15:0] half_val;
        logic [XLEN-1:0]    res;
        byte_val = word[{off, 3'b000} +: 8];
        half_val = word[{off[1], 4'b0000} +: 16];
        case (ltype)
            LT_LB:   res = {{(XLEN-8){byte_val[7]}}, byte_val};
            LT_LBU:  res = {{(XLEN-8){1'b0}}, byte_val};
            LT_LH:   res = {{(XLEN-16){half_val[15]}}, half_val};
            LT_LHU:  res = {{(XLEN-16){1'b0}}, half_val};
            default: res = word;
        endcase
        return res;
    endfunction

    // Halfword loads need an even offset; words (and unknown types) need zero.
    function automatic logic is_misaligned(
        input logic [2:0] ltype,
        input logic [1:0] off
    );
        logic mis;
        case (ltype)
            LT_LB, LT_LBU: mis = 1'b0;
            LT_LH, LT_LHU: mis = off[0];
            LT_LW:         mis = (off != 2'b00);
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // ---- stage p0: MEM-side result selection and write qualification ----
    logic            capture_p0;
    logic            misaligned_p0;
    logic            wr_en_p0;
    logic [XLEN-1:0] result_p0;

    // Build the value and controls that the MEM/WB register will capture.
    always_comb begin
        capture_p0    = !rst && !wb_flush && !mem_hold && mem_valid;
        misaligned_p0 = mem_memtoreg && is_misaligned(mem_load_type, mem_addr_lo);
        result_p0     = mem_alu_result;
        if (mem_jal || mem_jalr) begin
            result_p0 = mem_pc_plus4;
        end else if (mem_memtoreg) begin
            // A misaligned load carries the raw word through for diagnosis.
            result_p0 = misaligned_p0 ? mem_load_data
                                      : extract_load(mem_load_type, mem_addr_lo, mem_load_data);
        end
        wr_en_p0 = mem_wb_reg_file && (mem_rd != 5'd0) && !misaligned_p0;
    end

    // ---- stage p1: MEM/WB register ----
    logic            vld_p1;
    logic            wr_en_p1;
    logic            misaligned_p1;
    logic [4:0]      wr_addr_p1;
    logic [XLEN-1:0] wr_data_p1;

    // Load a bubble on reset, flush, hold or empty MEM slot; else capture.
    // Data is cleared too because a bubble must present all-zero outputs.
    always_ff @(posedge clk) begin
        if (!capture_p0) begin
            vld_p1        <= 1'b0;
            wr_en_p1      <= 1'b0;
            misaligned_p1 <= 1'b0;
            wr_addr_p1    <= 5'd0;
            wr_data_p1    <= '0;
        end else begin
            vld_p1        <= 1'b1;
            wr_en_p1      <= wr_en_p0;
            misaligned_p1 <= misaligned_p0;
            wr_addr_p1    <= wr_en_p0 ? mem_rd : 5'd0;
            wr_data_p1    <= result_p0;
        end
    end

    assign wb_valid      = vld_p1;
    assign wb_wr_en      = wr_en_p1;
    assign wb_misaligned = misaligned_p1;
    assign wb_wr_addr    = wr_addr_p1;
    assign wb_wr_data    = wr_data_p1;

`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] instret_cnt;

    // Count every captured instruction; flush does not clear the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= 64'h0;
        end else if (capture_p0) begin
            instret_cnt <= instret_cnt + 64'd1;
        end
    end

    assign wb_instret = instret_cnt;
`else
    assign wb_instret = 64'h0;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (WB) stage of the 5-stage RV32I pipeline and the writer end of the `register_file` write port. It registers MEM-stage results into the MEM/WB pipeline register and drives `wb_wr_en`, `wb_wr_addr` and `wb_wr_data` into `top_decode`. It aligns and sign/zero-extends raw load words per `mem_load_type` and selects the write-back source: ALU, load, or link PC+4. It also flags misaligned loads and optionally counts retired instructions.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_valid` input 1: a real instruction occupies the MEM stage.
- `mem_hold` input 1: MEM stage is stalled this cycle, so WB takes a bubble.
- `wb_flush` input 1: kill the instruction entering WB.
- `mem_rd` input 5: destination register.
- `mem_wb_reg_file` input 1: the instruction writes the register file.
- `mem_memtoreg` input 1: the result comes from load data.
- `mem_jal`, `mem_jalr` input 1 each: the result is the link value.
- `mem_load_type` input 3: LB=000, LH=001, LW=010, LBU=011, LHU=100; any other code is treated as LW.
- `mem_addr_lo` input 2: byte offset of the load address (`alu_result[1:0]`).
- `mem_alu_result` input 32: ALU output, including the LUI/AUIPC result.
- `mem_load_data` input 32: raw aligned word from data memory.
- `mem_pc_plus4` input 32: link value.
- `wb_wr_en` output 1: register-file write enable.
- `wb_wr_addr` output 5: write address.
- `wb_wr_data` output 32: write data.
- `wb_valid` output 1: a valid instruction is in WB this cycle.
- `wb_misaligned` output 1: the instruction in WB is a misaligned load; its write is suppressed.
- `wb_instret` output 64: retired-instruction count (see Configuration).

## Operation
- Single MEM/WB register, loaded every cycle. The priority order is:
  - `rst`: load a bubble.
  - `wb_flush`: load a bubble.
  - `mem_hold` or `!mem_valid`: load a bubble.
  - Otherwise capture the MEM inputs.
- A bubble means all outputs are 0 except `wb_instret`.
- Result selection, evaluated on the MEM inputs before registering:
  - `mem_jal | mem_jalr` selects `mem_pc_plus4`.
  - Otherwise `mem_memtoreg` selects the extracted load value.
  - Otherwise `mem_alu_result` is used.
- Load extraction:
  - LB/LBU: byte = `mem_load_data[8*off +: 8]`, sign- or zero-extended.
  - LH/LHU: halfword = `mem_load_data[16*off[1] +: 16]`, sign- or zero-extended.
  - LW: the whole word.
- Misalignment applies only when `mem_memtoreg=1`:
  - LH/LHU with `off[0]=1` is misaligned.
  - LW (or an unknown load type) with `off!=0` is misaligned.
- Misaligned load: `wb_misaligned=1`, `wb_wr_en=0`, `wb_valid=1`, and `wb_wr_data` holds the unextracted raw word.
- `wb_wr_en = valid & mem_wb_reg_file & (rd!=0) & !misaligned`, registered. `wb_wr_addr` is 0 whenever `wb_wr_en` is 0.
- Stores and branches (`mem_wb_reg_file=0`) still assert `wb_valid` but never `wb_wr_en`.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and are written into `register_file` at edge N+1. The register file's same-cycle forwarding covers the ID read.
- All outputs are registered; there is no combinational path from input to output.
- Reset values: `wb_wr_en=0`, `wb_wr_addr=0`, `wb_wr_data=0`, `wb_valid=0`, `wb_misaligned=0`, `wb_instret=0`.
- Reset asserted mid-stream discards the instruction being captured. The first capture occurs at the first edge with `rst=0`.
- `mem_hold` asserted for K cycles produces K bubble cycles. An instruction never retires twice, even if the MEM inputs stay unchanged across the hold.
- `wb_flush` and `mem_hold` asserted together produce a single bubble per cycle, identical to the flush-only case.
- `rd=0` with `mem_wb_reg_file=1` gives `wb_valid=1` and `wb_wr_en=0`.

## Configuration
- Macro: `WB_RETIRE_COUNTER_EN`.
- When defined: a 64-bit counter increments by 1 at each edge where a non-bubble is captured, including stores, branches and misaligned loads. It wraps from all-ones to 0. Reset clears it; `wb_flush` does not.
- When not defined: `wb_instret` is tied to 64'h0, no counter flops are present, and all other behaviour is identical.

## Test plan
- LB with `off=3`, data 32'h80FF_1234 -> `wb_wr_data`=32'hFFFF_FF80. The same input with LBU -> 32'h0000_0080. Both with `wb_wr_en=1` at the given rd.
- LH with `off=1`, rd=5 -> `wb_misaligned=1`, `wb_wr_en=0`, `wb_valid=1`. LHU with `off=2`, data 32'hBEEF_0000 -> 32'h0000_BEEF.
- JALR rd=1, `pc_plus4`=32'h0000_0104, `alu_result`=32'hDEAD_BEEF -> `wb_wr_data`=32'h0000_0104, `wb_wr_addr`=1.
- ADD rd=0, `alu_result`=7 -> `wb_valid=1`, `wb_wr_en=0`, `wb_wr_addr=0`.
- Valid ADD held by `mem_hold` for 3 cycles, then released -> exactly one `wb_wr_en` pulse (after release). With the macro defined, `wb_instret` advances by exactly 1.
- `rst` asserted in the same cycle as a valid LW -> all outputs 0 on the next cycle. With the macro defined, preload the counter to 64'hFFFF_FFFF_FFFF_FFFF (via force) and capture one instruction -> `wb_instret`=0.
